// File: rtl/demux_6to1_router.sv
// Routes one producer word to one of N_OUT single-entry holding registers chosen by in_sel.
// Out-of-range selects are accepted and dropped, then flagged for one cycle and counted.
module demux_6to1_router #(
  parameter int WIDTH = 32,
  parameter int N_OUT = 6,
  parameter int SEL_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   bad_sel,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic                        bad_q, bad_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [N_OUT-1:0] sel_hit;
  logic             sel_ok;
  logic             push;

  // One-hot decode of the select; an all-zero decode means the word will be dropped.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  assign sel_ok   = |sel_hit;
  // A full port can still accept when its consumer pops on the same edge.
  assign in_ready = sel_ok ? |(sel_hit & (~valid_q | out_ready)) : 1'b1;
  assign push     = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (push && sel_hit[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    bad_d = push && !sel_ok;
    cnt_d = cnt_q;
    if (bad_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the data holding registers are reset too, because out_data must read zero during reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      data_q  <= '0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign bad_sel   = bad_q;
  assign drop_cnt  = cnt_q;

endmodule
